// File: rtl/stack.sv
// rtl/stack.sv - LIFO stack with registered, one-cycle-lagged top-of-stack output
//
// Ports:
//   clock       - single clock, all state updates on rising edge
//   reset       - asynchronous active-high reset (clears sp and out, not mem)
//   io_dataIn   - value written on an accepted push
//   io_en       - operation enable; when low nothing changes
//   io_push     - push request (wins over io_pop when both set)
//   io_pop      - pop request
//   io_dataOut  - registered copy of the top of stack as of the previous enabled edge

module stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_dataIn,
    input  logic             io_en,
    input  logic             io_push,
    input  logic             io_pop,
    output logic [WIDTH-1:0] io_dataOut
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [SPW-1:0]   sp_q, sp_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             push_acc;
    logic             pop_acc;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    // Push has priority: a push request suppresses pop even when it is
    // itself rejected because the stack is full.
    assign push_acc = io_en & io_push & (sp_q != SP_FULL);
    assign pop_acc  = io_en & ~io_push & io_pop & (sp_q != '0);

    // Asynchronous read of the current top; the address is only meaningful
    // when sp_q > 0, which is the only case where rd_data is consumed.
    assign rd_addr = AW'(sp_q - SPW'(1));
    assign rd_data = mem_q[rd_addr];

    always_comb begin
        sp_d    = sp_q;
        out_d   = out_q;
        wr_en   = push_acc;
        wr_addr = sp_q[AW-1:0];
        wr_data = io_dataIn;

        if (push_acc) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop_acc) begin
            sp_d = sp_q - SPW'(1);
        end

        // Output samples the pre-edge top, independent of this cycle's op.
        if (io_en && (sp_q != '0)) begin
            out_d = rd_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp_q  <= '0;
            out_q <= '0;
        end else begin
            sp_q  <= sp_d;
            out_q <= out_d;
        end
    end

    // Storage is deliberately not reset; entries above sp are never read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign io_dataOut = out_q;

endmodule

// File: tb/tb_stack.sv
// tb/tb_stack.sv - self-checking testbench for stack

module tb_stack;

    logic        clock;
    logic        reset;
    logic [31:0] io_dataIn;
    logic        io_en;
    logic        io_push;
    logic        io_pop;
    logic [31:0] io_dataOut;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        en;
        logic        push;
        logic        pop;
        logic [31:0] din;
        logic [31:0] exp;
    } step_t;

    logic [31:0] exp_q [$];

    stack #(.DEPTH(8), .WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_dataIn  (io_dataIn),
        .io_en      (io_en),
        .io_push    (io_push),
        .io_pop     (io_pop),
        .io_dataOut (io_dataOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cycle(input logic en, input logic push, input logic pop, input logic [31:0] din);
        @(negedge clock);
        io_en     = en;
        io_push   = push;
        io_pop    = pop;
        io_dataIn = din;
        @(posedge clock);
        #1;
    endtask

    function automatic step_t mk(input logic en, input logic push, input logic pop,
                                 input logic [31:0] din, input logic [31:0] exp);
        step_t s;
        s.en = en; s.push = push; s.pop = pop; s.din = din; s.exp = exp;
        return s;
    endfunction

    task automatic test_reset;
        logic [31:0] exp;
        io_en = 1'b0; io_push = 1'b0; io_pop = 1'b0; io_dataIn = '0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (io_dataOut !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_async: got %h expected %h", io_dataOut, 32'h0);
        end
        // Enabled pushes while reset is held must have no effect.
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'h0);
            cycle(1'b1, 1'b1, 1'b0, 32'hDEAD_0000 + 32'(i));
            exp = exp_q.pop_front();
            tests_run++;
            if (io_dataOut !== exp) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, io_dataOut, exp);
            end
        end
        @(negedge clock);
        io_en = 1'b0; io_push = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        step_t s [$];
        logic [31:0] exp;
        s.push_back(mk(1, 1, 0, 32'h11, 32'h00));
        s.push_back(mk(1, 1, 0, 32'h22, 32'h11));
        s.push_back(mk(1, 0, 0, 32'h00, 32'h22));
        s.push_back(mk(1, 0, 1, 32'h00, 32'h22));
        s.push_back(mk(1, 0, 0, 32'h00, 32'h11));
        s.push_back(mk(1, 0, 1, 32'h00, 32'h11));
        s.push_back(mk(1, 0, 0, 32'h00, 32'h11));
        s.push_back(mk(1, 1, 0, 32'h77, 32'h11));
        s.push_back(mk(1, 0, 0, 32'h00, 32'h77));
        s.push_back(mk(1, 0, 1, 32'h00, 32'h77));
        foreach (s[i]) begin
            exp_q.push_back(s[i].exp);
            cycle(s[i].en, s[i].push, s[i].pop, s[i].din);
            exp = exp_q.pop_front();
            tests_run++;
            if (io_dataOut !== exp) begin
                tests_failed++;
                $display("FAIL basic[%0d]: got %h expected %h", i, io_dataOut, exp);
            end
        end
    endtask

    task automatic test_full;
        step_t s [$];
        logic [31:0] exp;
        // Stack empty, out = 0x77 on entry.
        for (int k = 1; k <= 9; k++)
            s.push_back(mk(1, 1, 0, 32'(k), (k == 1) ? 32'h77 : 32'(k - 1)));
        // Push+pop while full: push rejected, pop still suppressed.
        s.push_back(mk(1, 1, 1, 32'hEE, 32'h8));
        for (int i = 0; i < 8; i++)
            s.push_back(mk(1, 0, 1, 32'h0, 32'(8 - i)));
        s.push_back(mk(1, 0, 1, 32'h00, 32'h1));
        s.push_back(mk(1, 1, 0, 32'h99, 32'h1));
        s.push_back(mk(1, 0, 0, 32'h00, 32'h99));
        s.push_back(mk(1, 0, 1, 32'h00, 32'h99));
        foreach (s[i]) begin
            exp_q.push_back(s[i].exp);
            cycle(s[i].en, s[i].push, s[i].pop, s[i].din);
            exp = exp_q.pop_front();
            tests_run++;
            if (io_dataOut !== exp) begin
                tests_failed++;
                $display("FAIL full[%0d]: got %h expected %h", i, io_dataOut, exp);
            end
        end
    endtask

    task automatic test_push_pop_priority;
        step_t s [$];
        logic [31:0] exp;
        s.push_back(mk(1, 1, 0, 32'h11, 32'h99));
        s.push_back(mk(1, 1, 1, 32'h33, 32'h11));
        s.push_back(mk(1, 0, 0, 32'h00, 32'h33));
        s.push_back(mk(1, 0, 1, 32'h00, 32'h33));
        s.push_back(mk(1, 0, 1, 32'h00, 32'h11));
        s.push_back(mk(1, 0, 1, 32'h00, 32'h11));
        foreach (s[i]) begin
            exp_q.push_back(s[i].exp);
            cycle(s[i].en, s[i].push, s[i].pop, s[i].din);
            exp = exp_q.pop_front();
            tests_run++;
            if (io_dataOut !== exp) begin
                tests_failed++;
                $display("FAIL priority[%0d]: got %h expected %h", i, io_dataOut, exp);
            end
        end
    endtask

    task automatic test_enable;
        step_t s [$];
        logic [31:0] exp;
        s.push_back(mk(1, 1, 0, 32'h44, 32'h11));
        s.push_back(mk(1, 0, 0, 32'h00, 32'h44));
        for (int i = 0; i < 3; i++)
            s.push_back(mk(0, 1, 0, 32'hAA, 32'h44));
        s.push_back(mk(0, 0, 1, 32'h00, 32'h44));
        s.push_back(mk(1, 0, 0, 32'h00, 32'h44));
        s.push_back(mk(1, 0, 1, 32'h00, 32'h44));
        s.push_back(mk(1, 1, 0, 32'h66, 32'h44));
        s.push_back(mk(1, 0, 0, 32'h00, 32'h66));
        s.push_back(mk(1, 0, 1, 32'h00, 32'h66));
        foreach (s[i]) begin
            exp_q.push_back(s[i].exp);
            cycle(s[i].en, s[i].push, s[i].pop, s[i].din);
            exp = exp_q.pop_front();
            tests_run++;
            if (io_dataOut !== exp) begin
                tests_failed++;
                $display("FAIL enable[%0d]: got %h expected %h", i, io_dataOut, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        step_t s [$];
        logic [31:0] exp;
        s.push_back(mk(1, 1, 0, 32'h11, 32'h66));
        s.push_back(mk(1, 1, 0, 32'h22, 32'h11));
        s.push_back(mk(1, 1, 0, 32'h33, 32'h22));
        foreach (s[i]) begin
            exp_q.push_back(s[i].exp);
            cycle(s[i].en, s[i].push, s[i].pop, s[i].din);
            exp = exp_q.pop_front();
            tests_run++;
            if (io_dataOut !== exp) begin
                tests_failed++;
                $display("FAIL reset_mid_fill[%0d]: got %h expected %h", i, io_dataOut, exp);
            end
        end
        // Assert between edges: output must clear without a clock edge.
        io_en = 1'b0; io_push = 1'b0;
        reset = 1'b1;
        #1;
        tests_run++;
        if (io_dataOut !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got %h expected %h", io_dataOut, 32'h0);
        end
        @(negedge clock);
        reset = 1'b0;
        s.delete();
        s.push_back(mk(1, 0, 1, 32'h00, 32'h00));
        s.push_back(mk(1, 1, 0, 32'h55, 32'h00));
        s.push_back(mk(1, 0, 0, 32'h00, 32'h55));
        s.push_back(mk(1, 0, 1, 32'h00, 32'h55));
        foreach (s[i]) begin
            exp_q.push_back(s[i].exp);
            cycle(s[i].en, s[i].push, s[i].pop, s[i].din);
            exp = exp_q.pop_front();
            tests_run++;
            if (io_dataOut !== exp) begin
                tests_failed++;
                $display("FAIL reset_mid_after[%0d]: got %h expected %h", i, io_dataOut, exp);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] m_mem [8];
        int          m_sp;
        logic [31:0] m_out;
        logic        en, push, pop;
        logic [31:0] din, exp;
        io_en = 1'b0; io_push = 1'b0; io_pop = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_sp  = 0;
        m_out = '0;
        for (int i = 0; i < 300; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            push = ($urandom_range(0, 1) == 1);
            pop  = ($urandom_range(0, 1) == 1);
            din  = $urandom;
            if (en) begin
                if (m_sp > 0) m_out = m_mem[m_sp - 1];
                if (push) begin
                    if (m_sp < 8) begin
                        m_mem[m_sp] = din;
                        m_sp++;
                    end
                end else if (pop && m_sp > 0) begin
                    m_sp--;
                end
            end
            exp_q.push_back(m_out);
            cycle(en, push, pop, din);
            exp = exp_q.pop_front();
            tests_run++;
            if (io_dataOut !== exp) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %h expected %h", i, io_dataOut, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_push_pop_priority();
        test_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
